// File: rtl/sys_bus_ic_pkg.sv
// Shared definitions for the system-bus interconnect: FSM states, access
// control codes and the default address map of the reference system.
package sys_bus_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] CTRL_NONE = 3'b000;

    localparam logic [63:0] ROM_BASE  = 64'h0000_0000;
    localparam logic [63:0] ROM_SIZE  = 64'h0000_4000;
    localparam logic [63:0] GPIO_BASE = 64'h4000_0000;
    localparam logic [63:0] GPIO_SIZE = 64'h0000_0010;
    localparam logic [63:0] UART_BASE = 64'h5000_0000;
    localparam logic [63:0] UART_SIZE = 64'h0000_0010;
    localparam logic [63:0] DRAM_BASE = 64'h8000_0000;
    localparam logic [63:0] DRAM_SIZE = 64'h0000_1000;

    function automatic logic ctrl_active(input logic [2:0] i_ctrl);
        return i_ctrl != CTRL_NONE;
    endfunction

endpackage

// File: rtl/sys_bus_ic_decode.sv
// Address decoder: window match per slave plus lowest-index priority select.
module sys_bus_decode #(
    parameter int                          ADDR_W   = 64,
    parameter int                          N_SLV    = 4,
    parameter int                          SEL_W    = 2,
    parameter logic [N_SLV*ADDR_W-1:0]     SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0]     SLV_SIZE = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [SEL_W-1:0]  o_sel
);

    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            // Extra MSB of the difference is the borrow: addr below base never hits.
            logic [ADDR_W:0] w_diff;
            w_diff = {1'b0, i_addr} - {1'b0, SLV_BASE[k*ADDR_W +: ADDR_W]};
            if (!o_hit && !w_diff[ADDR_W] &&
                (w_diff[ADDR_W-1:0] < SLV_SIZE[k*ADDR_W +: ADDR_W])) begin
                o_hit = 1'b1;
                o_sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/sys_bus_ic.sv
// Registered single-master to N_SLV-slave bus interconnect with wait states,
// slave timeout and error responses for unmapped or illegal accesses.
module sys_bus_ic
    import sys_bus_ic_pkg::*;
#(
    parameter int                      ADDR_W   = 64,
    parameter int                      DATA_W   = 64,
    parameter int                      N_SLV    = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {N_SLV{64'h0}},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_SIZE = {N_SLV{64'h1000}},
    parameter int                      TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_req,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W-1:0]       m_wdata,
    input  logic [2:0]              m_rd_ctrl,
    input  logic [2:0]              m_wr_ctrl,
    output logic                    m_ready,
    output logic                    m_rvalid,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_err,
    output logic [N_SLV-1:0]        s_req,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    output logic [2:0]              s_rd_ctrl,
    output logic [2:0]              s_wr_ctrl,
    input  logic [N_SLV-1:0]        s_ack,
    input  logic [N_SLV*DATA_W-1:0] s_rdata
);

    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              r_state, w_next;
    logic [SEL_W-1:0]    r_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [N_SLV-1:0]    r_s_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_rd_ctrl;
    logic [2:0]          r_wr_ctrl;

    logic                w_hit;
    logic [SEL_W-1:0]    w_sel;
    logic                w_accept;
    logic                w_illegal;
    logic                w_ack;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_slv_rdata;
    logic                w_ready;
    logic                w_rvalid;

    sys_bus_decode #(
        .ADDR_W   (ADDR_W),
        .N_SLV    (N_SLV),
        .SEL_W    (SEL_W),
        .SLV_BASE (SLV_BASE),
        .SLV_SIZE (SLV_SIZE)
    ) u_decode (
        .i_addr (m_addr),
        .o_hit  (w_hit),
        .o_sel  (w_sel)
    );

    assign w_accept  = m_req && (r_state == ST_IDLE) &&
                       (ctrl_active(m_rd_ctrl) || ctrl_active(m_wr_ctrl));
    assign w_illegal = ctrl_active(m_rd_ctrl) && ctrl_active(m_wr_ctrl);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Only the selected slave's ack and data are looked at.
    always_comb begin
        w_ack       = 1'b0;
        w_slv_rdata = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (r_sel == SEL_W'(k)) begin
                w_ack       = s_ack[k];
                w_slv_rdata = s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_rvalid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (w_accept) w_next = (w_hit && !w_illegal) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: if (w_ack || w_timeout) w_next = ST_RESP;
            ST_RESP: begin
                w_rvalid = 1'b1;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_s_req   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_ctrl <= CTRL_NONE;
            r_wr_ctrl <= CTRL_NONE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_addr    <= m_addr;
                    r_wdata   <= m_wdata;
                    r_rd_ctrl <= m_rd_ctrl;
                    r_wr_ctrl <= m_wr_ctrl;
                    r_cnt     <= '0;
                    if (w_hit && !w_illegal) begin
                        r_sel   <= w_sel;
                        r_s_req <= N_SLV'(1) << w_sel;
                    end else begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_ack) begin
                        r_s_req <= '0;
                        r_err   <= 1'b0;
                        r_rdata <= ctrl_active(r_rd_ctrl) ? w_slv_rdata : '0;
                    end else if (w_timeout) begin
                        r_s_req <= '0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_ready   = w_ready;
    assign m_rvalid  = w_rvalid;
    assign m_rdata   = r_rdata;
    assign m_err     = r_err;
    assign s_req     = r_s_req;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;
    assign s_rd_ctrl = r_rd_ctrl;
    assign s_wr_ctrl = r_wr_ctrl;

endmodule

// File: tb/tb_sys_bus_ic.sv
// Scoreboard bench for sys_bus_ic: a driver pushes expected responses from a
// map-level reference model, a monitor pops and compares on each m_rvalid.
module tb_sys_bus_ic;
    import sys_bus_ic_pkg::*;

    localparam int TO = 16;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_req = 1'b0;
    logic [63:0]   m_addr = '0;
    logic [63:0]   m_wdata = '0;
    logic [2:0]    m_rd_ctrl = '0;
    logic [2:0]    m_wr_ctrl = '0;
    logic          m_ready, m_rvalid, m_err;
    logic [63:0]   m_rdata;
    logic [3:0]    s_req;
    logic [63:0]   s_addr, s_wdata;
    logic [2:0]    s_rd_ctrl, s_wr_ctrl;
    logic [3:0]    s_ack;
    logic [255:0]  s_rdata;

    logic [63:0]   map_base [4] = '{ROM_BASE, GPIO_BASE, UART_BASE, DRAM_BASE};
    logic [63:0]   map_size [4] = '{ROM_SIZE, GPIO_SIZE, UART_SIZE, DRAM_SIZE};
    logic [63:0]   slv_data [4];
    int            slv_lat  [4];
    int            scnt     [4];
    logic [3:0]    spur;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  rc;
        logic [2:0]  wc;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        logic [3:0]  mask;
        int          scyc;
        int          issue;
    } exp_t;

    exp_t sb[$];

    sys_bus_ic #(
        .ADDR_W   (64),
        .DATA_W   (64),
        .N_SLV    (4),
        .SLV_BASE ({DRAM_BASE, UART_BASE, GPIO_BASE, ROM_BASE}),
        .SLV_SIZE ({DRAM_SIZE, UART_SIZE, GPIO_SIZE, ROM_SIZE}),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rd_ctrl (m_rd_ctrl),
        .m_wr_ctrl (m_wr_ctrl),
        .m_ready   (m_ready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .s_req     (s_req),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rd_ctrl (s_rd_ctrl),
        .s_wr_ctrl (s_wr_ctrl),
        .s_ack     (s_ack),
        .s_rdata   (s_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        spur <= 4'($urandom);
        for (int i = 0; i < 4; i++) scnt[i] <= s_req[i] ? scnt[i] + 1 : 0;
    end

    // Slave models: ack after slv_lat cycles of s_req; unselected slaves chatter.
    always_comb begin
        s_ack   = '0;
        s_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            s_ack[i] = s_req[i] ? (scnt[i] >= slv_lat[i]) : spur[i];
            s_rdata[i*64 +: 64] = slv_data[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: map lookup, then response timing from the slave's latency.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] wd,
                                   input logic [2:0] rc, input logic [2:0] wc, input int lat);
        exp_t e;
        int   hit = -1;
        e.addr = a; e.wdata = wd; e.rc = rc; e.wc = wc;
        for (int i = 3; i >= 0; i--)
            if (a >= map_base[i] && (a - map_base[i]) < map_size[i]) hit = i;
        if (hit < 0 || (rc != 0 && wc != 0)) begin
            e.rdata = '0; e.err = 1'b1; e.lat = 1; e.mask = '0; e.scyc = 0;
        end else begin
            e.mask = 4'(1 << hit);
            if (lat >= TO) begin
                e.rdata = '0; e.err = 1'b1; e.lat = TO + 1; e.scyc = TO;
            end else begin
                e.rdata = (rc != 0) ? slv_data[hit] : '0;
                e.err = 1'b0; e.lat = lat + 2; e.scyc = lat + 1;
            end
        end
        return e;
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!m_ready && w < 200) begin @(negedge clk); w++; end
        chk("ready_wait", 64'(m_ready), 64'd1);
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] wd,
                         input logic [2:0] rc, input logic [2:0] wc, input int lat);
        exp_t e;
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            slv_lat[i]  = lat;
            slv_data[i] = {$urandom, $urandom};
        end
        e = model(a, wd, rc, wc, lat);
        e.issue = cyc;
        if (rc != 0 || wc != 0) sb.push_back(e);
        m_req = 1'b1; m_addr = a; m_wdata = wd; m_rd_ctrl = rc; m_wr_ctrl = wc;
        @(negedge clk);
        m_req = 1'b0; m_addr = {$urandom, $urandom}; m_rd_ctrl = 3'($urandom); m_wr_ctrl = 3'($urandom);
    endtask

    logic [3:0] acc_mask = '0;
    int         acc_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            acc_mask = '0;
            acc_cyc  = 0;
        end else begin
            if (s_req != 0) begin
                acc_mask |= s_req;
                acc_cyc++;
                if (sb.size() == 0) chk("sreq_unexpected", 64'(s_req), 64'd0);
                else begin
                    chk("s_addr",    s_addr,          sb[0].addr);
                    chk("s_wdata",   s_wdata,         sb[0].wdata);
                    chk("s_rd_ctrl", 64'(s_rd_ctrl),  64'(sb[0].rc));
                    chk("s_wr_ctrl", 64'(s_wr_ctrl),  64'(sb[0].wc));
                end
            end
            if (m_rvalid) begin
                if (sb.size() == 0) chk("rvalid_unexpected", 64'(m_rvalid), 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("m_rdata",   m_rdata,            e.rdata);
                    chk("m_err",     64'(m_err),         64'(e.err));
                    chk("latency",   64'(cyc - e.issue), 64'(e.lat));
                    chk("sreq_mask", 64'(acc_mask),      64'(e.mask));
                    chk("sreq_cyc",  64'(acc_cyc),       64'(e.scyc));
                    chk("ready_resp", 64'(m_ready),      64'd0);
                end
                acc_mask = '0;
                acc_cyc  = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin slv_lat[i] = 0; slv_data[i] = '0; scnt[i] = 0; end
        spur = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  64'(m_ready),  64'd1);
        chk("rst_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_rdata",  m_rdata,       64'd0);
        chk("rst_err",    64'(m_err),    64'd0);
        chk("rst_sreq",   64'(s_req),    64'd0);
        chk("rst_saddr",  s_addr,        64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the address map.
        issue(64'h8000_0008, 64'h0, 3'd3, 3'd0, 0);
        issue(64'h4000_0004, 64'hA5, 3'd0, 3'd3, 3);
        issue(64'h6000_0000, 64'h0, 3'd3, 3'd0, 0);
        issue(64'h5000_0000, 64'h0, 3'd1, 3'd0, NEVER);
        issue(64'h0000_0100, 64'h0, 3'd1, 3'd0, 0);
        issue(64'h8000_0000, 64'h0, 3'd1, 3'd1, 0);
        issue(64'h0000_0000, 64'h0, 3'd5, 3'd0, TO - 1);
        issue(64'h8000_0FFF, 64'h0, 3'd2, 3'd0, TO);
        issue(64'h8000_1000, 64'h0, 3'd2, 3'd0, 0);
        issue(64'h3FFF_FFFF, 64'h0, 3'd2, 3'd0, 0);
        issue(64'h0000_3FFF, 64'h0, 3'd4, 3'd0, 1);

        // Request with no access code is ignored.
        wait_ready();
        m_req = 1'b1; m_addr = 64'h8000_0000; m_rd_ctrl = 3'd0; m_wr_ctrl = 3'd0;
        @(negedge clk);
        m_req = 1'b0;
        chk("ignored_ready",  64'(m_ready),  64'd1);
        chk("ignored_sreq",   64'(s_req),    64'd0);
        @(negedge clk);
        chk("ignored_rvalid", 64'(m_rvalid), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 70; n++) begin
            int          k = int'($urandom_range(0, 9));
            int          s = int'($urandom_range(0, 3));
            int          lat = ($urandom_range(0, 7) == 0) ? TO - 1 + int'($urandom_range(0, 1))
                                                           : int'($urandom_range(0, 4));
            logic [63:0] a;
            logic [63:0] wd = {$urandom, $urandom};
            logic [2:0]  rc = 3'($urandom_range(1, 7));
            logic [2:0]  wc = 3'($urandom_range(1, 7));
            logic        wr = 1'($urandom);
            if (k <= 5)      a = map_base[s] + 64'($urandom_range(0, int'(map_size[s]) - 1));
            else if (k == 6) a = map_base[s] + map_size[s] - 64'($urandom_range(0, 1));
            else             a = {$urandom, $urandom};
            if (k == 8)      issue(a, wd, rc, wc, lat);
            else if (k == 9) issue(a, wd, 3'd0, 3'd0, lat);
            else if (wr)     issue(a, wd, 3'd0, wc, lat);
            else             issue(a, wd, rc, 3'd0, lat);
        end

        // Reset while a slave is being waited on.
        issue(64'h8000_0010, 64'h0, 3'd3, 3'd0, 8);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sreq",   64'(s_req),    64'd0);
        chk("midrst_ready",  64'(m_ready),  64'd1);
        chk("midrst_rvalid", 64'(m_rvalid), 64'd0);
        chk("midrst_err",    64'(m_err),    64'd0);
        chk("midrst_rdata",  m_rdata,       64'd0);
        chk("midrst_saddr",  s_addr,        64'd0);
        sb.delete();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(64'h4000_0008, 64'h5A, 3'd0, 3'd2, 2);

        begin
            int w = 0;
            while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
